// File: rtl/fir_pkg.sv
// Shared FIR definitions: default sizes, loader state encoding, index-width helper
// and a slice macro for unpacking the flat weight bus.
`define FIR_WEIGHT(vec, k, dw) vec[(k)*(dw) +: (dw)]

package fir_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int NUM_TAPS_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2
  } fir_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient stream handshake: the writer drives valid/coeff, the loader answers ready.
interface fir_coeff_loader_if import fir_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                         is_valid;
  logic                         os_ready;
  logic signed [DATA_WIDTH-1:0] isv_coeff;

  modport master (
    output is_valid,
    output isv_coeff,
    input  os_ready
  );

  modport slave (
    input  is_valid,
    input  isv_coeff,
    output os_ready
  );

endinterface

// File: rtl/fir_weight_bank.sv
// Shadow/active coefficient register pair per tap: indexed writes fill the shadow
// bank, a single copy enable moves the whole set into the active bank on one edge.
module fir_weight_bank import fir_pkg::*; #(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NUM_TAPS   = NUM_TAPS_DEF,
  localparam int IDX_W      = clog2(NUM_TAPS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_wr_en,
  input  logic [IDX_W-1:0]               iv_wr_idx,
  input  logic signed [DATA_WIDTH-1:0]   isv_wr_data,
  input  logic                           i_copy_en,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_active
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
      logic signed [DATA_WIDTH-1:0] shadow_q;
      logic signed [DATA_WIDTH-1:0] active_q;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          shadow_q <= '0;
          active_q <= '0;
        end else begin
          if (i_wr_en && (iv_wr_idx == IDX_W'(gi))) begin
            shadow_q <= isv_wr_data;
          end
          if (i_copy_en) begin
            active_q <= shadow_q;
          end
        end
      end

      assign ov_active[gi*DATA_WIDTH +: DATA_WIDTH] = active_q;
    end
  endgenerate

endmodule

// File: rtl/fir_coeff_loader.sv
// Collects NUM_TAPS coefficients into a shadow bank and commits them atomically
// to the active bank that feeds the tap chain.
module fir_coeff_loader import fir_pkg::*; #(
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NUM_TAPS   = NUM_TAPS_DEF,
  localparam int IDX_W      = clog2(NUM_TAPS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  fir_coeff_loader_if.slave              coeff_if,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic [IDX_W:0]                 ov_count,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_start_err
);

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(NUM_TAPS - 1);

  fir_state_e     state_q;
  logic           ready_q;
  logic           busy_q;
  logic           done_q;
  logic           start_err_q;
  logic [IDX_W:0] count_q;

  logic accept;
  logic abort_load;
  logic wr_en;
  logic copy_en;

  assign accept     = coeff_if.is_valid && ready_q;
  assign abort_load = i_abort && (state_q == ST_LOAD);
  // A beat arriving together with abort must not touch the shadow bank.
  assign wr_en      = accept && !abort_load;
  assign copy_en    = (state_q == ST_COMMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      start_err_q <= 1'b0;
      count_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      start_err_q <= i_start && busy_q;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q <= ST_LOAD;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            count_q <= '0;
          end
        end
        ST_LOAD: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (accept) begin
            count_q <= count_q + 1'b1;
            if (count_q == LAST_IDX) begin
              state_q <= ST_COMMIT;
              ready_q <= 1'b0;
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fir_weight_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS)
  ) u_bank (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_wr_en     (wr_en),
    .iv_wr_idx   (count_q[IDX_W-1:0]),
    .isv_wr_data (coeff_if.isv_coeff),
    .i_copy_en   (copy_en),
    .ov_active   (ov_weights)
  );

  assign coeff_if.os_ready = ready_q;
  assign ov_count          = count_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_start_err       = start_err_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed and random stimulus for fir_coeff_loader, checked every cycle against a
// transaction-level model (queue of accepted beats, set committed one cycle later).
module tb_fir_coeff_loader;

  localparam int DW = 24;
  localparam int NT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;

  fir_coeff_loader_if #(.DATA_WIDTH(DW)) cif ();

  logic [NT*DW-1:0] weights;
  logic [3:0]       count;
  logic             busy;
  logic             done;
  logic             serr;

  always #5 clk = ~clk;

  fir_coeff_loader #(
    .DATA_WIDTH (DW),
    .NUM_TAPS   (NT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_abort     (abort),
    .coeff_if    (cif),
    .ov_weights  (weights),
    .ov_count    (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_start_err (serr)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: committed set, beats of the load in progress, and pending flags.
  logic [DW-1:0] m_active [NT];
  logic [DW-1:0] m_buf [$];
  bit m_loading, m_pending, m_done, m_err;
  int accepted_this;

  task automatic check(input string tag, input logic [NT*DW-1:0] got,
                       input logic [NT*DW-1:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NT*DW-1:0] m_vec();
    logic [NT*DW-1:0] v;
    for (int k = 0; k < NT; k++) v[k*DW +: DW] = m_active[k];
    return v;
  endfunction

  task automatic model_reset();
    m_loading = 0;
    m_pending = 0;
    m_done    = 0;
    m_err     = 0;
    m_buf.delete();
    for (int k = 0; k < NT; k++) m_active[k] = '0;
  endtask

  // One clock: apply inputs, compare outputs mid-cycle, advance the model.
  task automatic step(input bit s, input bit a, input bit v, input logic [DW-1:0] c,
                      input bit r);
    start = s;
    abort = a;
    cif.is_valid  = v;
    cif.isv_coeff = c;
    rst = r;
    @(negedge clk);
    check("ready", cif.os_ready, m_loading);
    check("busy", busy, m_loading || m_pending);
    check("done", done, m_done);
    check("start_err", serr, m_err);
    check("count", count, m_buf.size());
    check("weights", weights, m_vec());
    accepted_this = 0;
    if (r) begin
      model_reset();
    end else begin
      m_err  = s && (m_loading || m_pending);
      m_done = m_pending;
      if (m_pending) begin
        for (int k = 0; k < NT; k++) m_active[k] = m_buf[k];
        m_pending = 0;
      end else if (m_loading) begin
        if (a) begin
          m_loading = 0;
          m_buf.delete();
        end else if (v) begin
          m_buf.push_back(c);
          accepted_this = 1;
          if (m_buf.size() == NT) begin
            m_loading = 0;
            m_pending = 1;
          end
        end
      end else if (s) begin
        m_loading = 1;
        m_buf.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  task automatic load_seq(input bit rnd);
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < NT; k++) step(0, 0, 1, rnd ? DW'($urandom) : DW'(k + 1), 0);
    idle(3);
  endtask

  task automatic check_taps(input string tag);
    for (int k = 0; k < NT; k++)
      check($sformatf("%s_tap%0d", tag, k), weights[k*DW +: DW], DW'(k + 1));
  endtask

  task automatic alt_load_abort(input int abort_beat);
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < NT; k++)
      step(0, (k == abort_beat), 1, (k % 2 == 0) ? 24'h7FFFFF : 24'h800000, 0);
    idle(3);
  endtask

  initial begin
    int guard;
    int got_beats;
    model_reset();
    cif.is_valid  = 1'b0;
    cif.isv_coeff = '0;

    // Reset held, then released
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, 1);
    idle(2);

    // Back-to-back load of 1..8
    load_seq(0);
    check_taps("b2b");

    // Random valid gaps
    step(1, 0, 0, '0, 0);
    got_beats = 0;
    guard = 0;
    while (got_beats < NT && guard < 200) begin
      step(0, 0, $urandom_range(0, 1) == 1, DW'($urandom), 0);
      got_beats += accepted_this;
      guard++;
    end
    check("rand_load_timeout", guard < 200, 1'b1);
    idle(3);

    // Abort on 5th beat and on 8th beat over a 1..8 preload
    load_seq(0);
    alt_load_abort(4);
    check_taps("abort5");
    alt_load_abort(NT - 1);
    check_taps("abort8");

    // Start and abort together while idle: start wins
    step(1, 1, 0, '0, 0);
    idle(1);
    step(0, 1, 0, '0, 0);
    idle(1);

    // Start pulsed mid-load
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, DW'(k + 1), 0);
    step(1, 0, 1, DW'(4), 0);
    for (int k = 4; k < NT; k++) step(0, 0, 1, DW'(k + 1), 0);
    step(1, 0, 0, '0, 0);
    idle(3);
    check_taps("midstart");

    // Reset after three beats, then a clean load
    step(1, 0, 0, '0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, DW'($urandom), 0);
    step(0, 0, 0, '0, 1);
    idle(2);
    load_seq(1);

    // Random soak
    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, ($urandom % 12) == 0, $urandom_range(0, 1) == 1,
           DW'($urandom), ($urandom % 97) == 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
